// File: rtl/frogger_pkg.sv
// Shared playfield geometry, facing/state encodings and a water-row helper
// used by the frog motion controller and its neighbours.
package frogger_pkg;

    localparam int GRID       = 40;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int FROG_MAX_X = 600;
    localparam int HOME_Y     = 40;
    localparam int FROG_MAX_Y = 440;
    localparam int WATER_Y0   = 80;
    localparam int WATER_Y1   = 239;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        RIGHT = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        HOP,
        DEAD,
        GAME_OVER
    } frog_state_t;

    function automatic logic in_water(input logic [10:0] y);
        return (y >= 11'(WATER_Y0)) && (y <= 11'(WATER_Y1));
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Two-flop rising-edge detector turning the vsync-rate frame_clk level into
// a one-Clk tick; shared with the car and lily-pad movers.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic frame_clk,
    output logic tick
);

    logic q1, q2;

    // Loading both flops with the live level on reset swallows any edge that
    // was in progress, so no spurious tick follows reset release.
    always_ff @(posedge clk) begin
        if (reset) begin
            q1 <= frame_clk;
            q2 <= frame_clk;
        end else begin
            q1 <= frame_clk;
            q2 <= q1;
        end
    end

    assign tick = q1 & ~q2;

endmodule

// File: rtl/frog_motion_ctrl.sv
// Frog position/facing owner: grid hops animated over HOP_FRAMES frames,
// lily-pad riding, death/respawn, lives and home-row wins, one step per frame.
module frog_motion_ctrl
    import frogger_pkg::*;
#(
    parameter int HOP_FRAMES   = 5,
    parameter int DEATH_FRAMES = 30,
    parameter int START_LIVES  = 3,
    parameter int START_X      = 320,
    parameter int START_Y      = 440
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic [3:0]  Car_Collision,
    input  logic [3:0]  LPad_Collision,
    input  logic [3:0]  ride_dx,
    output logic [10:0] FrogX,
    output logic [10:0] FrogY,
    output logic [1:0]  cur_Frog_Direction,
    output logic        frog_dead,
    output logic [1:0]  lives,
    output logic        win_pulse
);

    localparam int HW = $clog2(HOP_FRAMES + 1);
    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam logic [10:0] STEP = 11'(GRID / HOP_FRAMES);
    localparam logic [10:0] RESP_X = 11'(START_X);
    localparam logic [10:0] RESP_Y = 11'(START_Y);

    logic            tick;
    frog_state_t     state;
    dir_t            dir_q;
    logic [HW-1:0]   hop_cnt;
    logic [DW-1:0]   death_cnt;
    logic [3:0]      key_prev;
    logic [3:0]      keys, key_new;

    dir_t               key_dir;
    logic               key_hit;
    logic signed [11:0] x_s, y_s, off_x, off_y, tgt_x, tgt_y, ride_x;
    logic               tgt_ok;
    logic [10:0]        water_x, step_x, step_y;
    logic               water_die;

    frame_tick_gen u_tick (
        .clk       (Clk),
        .reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign keys               = {up, down, left, right};
    assign key_new            = keys & ~key_prev;
    assign key_hit            = |key_new;
    assign cur_Frog_Direction = dir_q;
    assign x_s                = $signed({1'b0, FrogX});
    assign y_s                = $signed({1'b0, FrogY});

    // Key decode (up > down > left > right) and hop target legality.
    always_comb begin
        key_dir = UP;
        off_x   = '0;
        off_y   = '0;
        if (key_new[3]) begin
            key_dir = UP;
            off_y   = -12'sd40;
        end else if (key_new[2]) begin
            key_dir = DOWN;
            off_y   = 12'sd40;
        end else if (key_new[1]) begin
            key_dir = LEFT;
            off_x   = -12'sd40;
        end else if (key_new[0]) begin
            key_dir = RIGHT;
            off_x   = 12'sd40;
        end
        tgt_x  = x_s + off_x;
        tgt_y  = y_s + off_y;
        tgt_ok = (tgt_x >= 12'sd0) && (tgt_x <= 12'(FROG_MAX_X)) &&
                 (tgt_y >= 12'(HOME_Y)) && (tgt_y <= 12'(FROG_MAX_Y));
    end

    // Pad ride: out-of-range results are clamped to the edge and kill the frog.
    always_comb begin
        ride_x    = x_s + {{8{ride_dx[3]}}, ride_dx};
        water_x   = FrogX;
        water_die = 1'b1;
        if (|LPad_Collision) begin
            if (ride_x < 12'sd0) begin
                water_x = '0;
            end else if (ride_x > 12'(FROG_MAX_X)) begin
                water_x = 11'(FROG_MAX_X);
            end else begin
                water_x   = ride_x[10:0];
                water_die = 1'b0;
            end
        end
    end

    always_comb begin
        step_x = FrogX;
        step_y = FrogY;
        case (dir_q)
            UP:    step_y = FrogY - STEP;
            DOWN:  step_y = FrogY + STEP;
            LEFT:  step_x = FrogX - STEP;
            RIGHT: step_x = FrogX + STEP;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            FrogX     <= RESP_X;
            FrogY     <= RESP_Y;
            dir_q     <= UP;
            lives     <= 2'(START_LIVES);
            frog_dead <= 1'b0;
            win_pulse <= 1'b0;
            hop_cnt   <= '0;
            death_cnt <= '0;
            key_prev  <= '0;
        end else begin
            win_pulse <= 1'b0;
            if (tick) begin
                key_prev <= keys;
                case (state)
                    IDLE: begin
                        if (|Car_Collision) begin
                            state     <= DEAD;
                            frog_dead <= 1'b1;
                            death_cnt <= '0;
                            lives     <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                        end else if (key_hit) begin
                            dir_q <= key_dir;
                            if (tgt_ok) begin
                                state   <= HOP;
                                hop_cnt <= '0;
                            end
                        end else if (in_water(FrogY)) begin
                            FrogX <= water_x;
                            if (water_die) begin
                                state     <= DEAD;
                                frog_dead <= 1'b1;
                                death_cnt <= '0;
                                lives     <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                            end
                        end
                    end
                    HOP: begin
                        if (|Car_Collision) begin
                            state     <= DEAD;
                            frog_dead <= 1'b1;
                            death_cnt <= '0;
                            lives     <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                        end else begin
                            hop_cnt <= hop_cnt + 1'b1;
                            FrogX   <= step_x;
                            FrogY   <= step_y;
                            if (hop_cnt == HW'(HOP_FRAMES - 1)) begin
                                state <= IDLE;
                                // Home row: pulse and send the frog straight back to the start.
                                if (step_y == 11'(HOME_Y)) begin
                                    win_pulse <= 1'b1;
                                    FrogX     <= RESP_X;
                                    FrogY     <= RESP_Y;
                                    dir_q     <= UP;
                                end
                            end
                        end
                    end
                    DEAD: begin
                        death_cnt <= death_cnt + 1'b1;
                        if (death_cnt == DW'(DEATH_FRAMES - 1)) begin
                            if (lives == 2'd0) begin
                                state <= GAME_OVER;
                            end else begin
                                state     <= IDLE;
                                frog_dead <= 1'b0;
                                FrogX     <= RESP_X;
                                FrogY     <= RESP_Y;
                                dir_q     <= UP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
